// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard detector: load-use and MDU HI/LO stalls, drives PC/IF_ID enables and ID_EX bubble.
// Optional stall performance counter enabled by defining STALL_PERF_EN.
module hazard_stall_ctrl #(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_RegisterRt,
  input  logic [4:0]       IF_ID_RegisterRs,
  input  logic [4:0]       IF_ID_RegisterRt,
  input  logic             IF_ID_UsesRs,
  input  logic             IF_ID_UsesRt,
  input  logic             IF_ID_UsesHiLo,
  input  logic             ID_EX_MduStart,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Bubble,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned    CW     = $clog2(MDU_LAT);
  localparam logic [CW-1:0]  RELOAD = CW'(MDU_LAT - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load_use;
  logic            hilo_stall;
  logic            stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start while already busy simply restarts the latency window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ID_EX_MduStart) begin
      state_d = BUSY;
      cnt_d   = RELOAD;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) state_d = IDLE;
    end
  end

  always_comb begin
    load_use = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
               ((IF_ID_UsesRs && (ID_EX_RegisterRt == IF_ID_RegisterRs)) ||
                (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));
    // Outputs are held at their idle values while reset is asserted.
    mdu_busy     = rst_n && (ID_EX_MduStart || (state_q == BUSY));
    mdu_done     = (state_q == BUSY) && (cnt_q == CW'(1));
    hilo_stall   = mdu_busy && IF_ID_UsesHiLo;
    stall        = rst_n && (load_use || hilo_stall);
    PCWrite      = !stall;
    IF_ID_Write  = !stall;
    ID_EX_Bubble = stall;
  end

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else if (stall) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule
